pc_sequencer: RTL

Next-PC controller for the pipelined datapath: owns the program counter register and decides every cycle whether the PC advances sequentially, holds for a hazard, redirects for a branch or jump, or halts. It sits at the front of the IF stage and feeds the instruction memory address. It also drives the IF/ID and ID/EX flush controls that squash wrong-path instructions.

---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_sequencer_if.sv | 30 +++
 rtl/pc_sequencer_next_mux.sv | 55 +++++
 rtl/pc_sequencer.sv | 76 +++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the next-PC controller: state encoding, PC width
// and the sequential increment.
package pc_sequencer_pkg;

    localparam int          PC_WIDTH = 32;
    localparam logic [31:0] PC_INC   = 32'd4;

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_RUN   = 2'b01,
        ST_HALT  = 2'b10
    } pc_state_e;

    // Fetch addresses are word aligned; targets lose their low two bits.
    function automatic logic [PC_WIDTH-1:0] align_word(input logic [PC_WIDTH-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the pipeline control logic (master) and the PC sequencer
// (slave). There is no valid/ready pairing on this bus: every request input
// is a level sampled once per cycle, and every output is valid every cycle.
interface pc_sequencer_if;

    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic        JumpReg;
    logic [31:0] JumpTarget;
    logic        HaltReq;
    logic [31:0] PCResult;
    logic [31:0] PCPlus4;
    logic        FetchValid;
    logic        FlushIFID;
    logic        FlushIDEX;
    logic        Halted;

    modport master (
        output Stall, BranchTaken, BranchTarget, Jump, JumpReg, JumpTarget, HaltReq,
        input  PCResult, PCPlus4, FetchValid, FlushIFID, FlushIDEX, Halted
    );

    modport slave (
        input  Stall, BranchTaken, BranchTarget, Jump, JumpReg, JumpTarget, HaltReq,
        output PCResult, PCPlus4, FetchValid, FlushIFID, FlushIDEX, Halted
    );

endinterface

// File: rtl/pc_sequencer_next_mux.sv
// Priority select of the next PC plus the flush flags for one RUN cycle.
// Optional macro PC_DELAY_SLOT_EN: MIPS branch delay slot flush behaviour.
module pc_sequencer_next_mux
    import pc_sequencer_pkg::*;
(
    input  logic                run_en,
    input  logic                Stall,
    input  logic                BranchTaken,
    input  logic [PC_WIDTH-1:0] BranchTarget,
    input  logic                Jump,
    input  logic                JumpReg,
    input  logic [PC_WIDTH-1:0] JumpTarget,
    input  logic                HaltReq,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [PC_WIDTH-1:0] pc_plus4,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic                halt_go,
    output logic                flush_ifid,
    output logic                flush_idex
);

    logic jump_any;
    assign jump_any = Jump | JumpReg;

    // Branch (oldest instruction, in EX) beats everything younger in ID/IF.
    always_comb begin
        next_pc    = pc_plus4;
        halt_go    = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (BranchTaken) begin
            next_pc = align_word(BranchTarget);
`ifdef PC_DELAY_SLOT_EN
            flush_ifid = run_en;
`else
            flush_ifid = run_en;
            flush_idex = run_en;
`endif
        end else if (jump_any && !Stall) begin
            next_pc = align_word(JumpTarget);
`ifdef PC_DELAY_SLOT_EN
            flush_ifid = 1'b0;
`else
            flush_ifid = run_en;
`endif
        end else if (Stall) begin
            next_pc = pc;
        end else if (HaltReq) begin
            next_pc    = pc;
            halt_go    = 1'b1;
            flush_ifid = run_en;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the PC register and the RESET/RUN/HALT state.
// Optional macro PC_DELAY_SLOT_EN (see pc_sequencer_next_mux).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic             Clk,
    input  logic             Reset,
    pc_sequencer_if.slave    bus,
    output logic [1:0]       DbgState
);

    pc_state_e             state, state_nxt;
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   pc_plus4;
    logic [PC_WIDTH-1:0]   next_pc;
    logic                  halt_go;
    logic                  run_en;
    logic                  flush_ifid;
    logic                  flush_idex;

    assign pc_plus4 = pc + PC_INC;
    // Flushes only exist in RUN and are suppressed while reset is asserted.
    assign run_en   = (state == ST_RUN) && Reset;

    pc_sequencer_next_mux u_next_mux (
        .run_en       (run_en),
        .Stall        (bus.Stall),
        .BranchTaken  (bus.BranchTaken),
        .BranchTarget (bus.BranchTarget),
        .Jump         (bus.Jump),
        .JumpReg      (bus.JumpReg),
        .JumpTarget   (bus.JumpTarget),
        .HaltReq      (bus.HaltReq),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .next_pc      (next_pc),
        .halt_go      (halt_go),
        .flush_ifid   (flush_ifid),
        .flush_idex   (flush_idex)
    );

    // State and PC registers; PC only moves while running.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= ST_RESET;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (state == ST_RUN) begin
                pc <= next_pc;
            end
        end
    end

    // Next-state decode: RESET always leaves for RUN, HALT is sticky.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET: state_nxt = ST_RUN;
            ST_RUN:   state_nxt = halt_go ? ST_HALT : ST_RUN;
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_RESET;
        endcase
    end

    assign bus.PCResult   = pc;
    assign bus.PCPlus4    = pc_plus4;
    assign bus.FetchValid = (state == ST_RUN);
    assign bus.Halted     = (state == ST_HALT);
    assign bus.FlushIFID  = flush_ifid;
    assign bus.FlushIDEX  = flush_idex;
    assign DbgState       = state;

endmodule
